fnd_multi_ctrl: RTL and testbench

Parametrised multi-channel 7-segment display controller: selects one of `NUM_CH` slave-register values, converts it from binary to BCD with a sequential converter, and drives a `DIGITS`-digit multiplexed common-anode display. It replaces the fixed 5-channel, one-hot-only FND path between the SPI slave register bank and the board FND pins. It also adds an auto-rotate mode that cycles through all channels, and a dash overflow indication.

---
 rtl/fnd_multi_ctrl_if.sv | 26 ++
 rtl/fnd_multi_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_fnd_multi_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fnd_multi_ctrl_if.sv
// Channel-select inputs and multiplexed display outputs of fnd_multi_ctrl.
interface fnd_multi_ctrl_if #(
    parameter int NUM_CH = 5,
    parameter int DATA_W = 8,
    parameter int DIGITS = 4
);
    localparam int CH_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0]        sw;
    logic                     mode_auto;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [7:0]               fndFont;
    logic [DIGITS-1:0]        fndCom;
    logic [CH_W-1:0]          ch_idx;
    logic                     conv_busy;

    modport master (
        output sw, mode_auto, ch_data,
        input  fndFont, fndCom, ch_idx, conv_busy
    );

    modport slave (
        input  sw, mode_auto, ch_data,
        output fndFont, fndCom, ch_idx, conv_busy
    );
endinterface

// File: rtl/fnd_multi_ctrl.sv
// Multi-channel 7-segment controller: channel select, sequential binary-to-BCD, digit scan.
// Define FND_LZB_EN to enable leading-zero blanking.
module fnd_multi_ctrl #(
    parameter int NUM_CH     = 5,
    parameter int DATA_W     = 8,
    parameter int DIGITS     = 4,
    parameter int SCAN_DIV   = 100000,
    parameter int ROTATE_DIV = 100000000
) (
    input logic             clk,
    input logic             reset,
    fnd_multi_ctrl_if.slave bus
);
    localparam int CH_W   = $clog2(NUM_CH);
    localparam int BCD_W  = 4 * DIGITS;
    localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int ROT_W  = (ROTATE_DIV > 1) ? $clog2(ROTATE_DIV) : 1;
    localparam int STEP_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0] OVF_LIMIT = pow10(DIGITS);

    function automatic logic [7:0] digit_font(
        input logic [BCD_W-1:0] bcd,
        input logic             ovf,
        input logic             blank,
        input logic             auto_on,
        input logic [DIG_W-1:0] d
    );
        logic [3:0] nib;
        logic [7:0] seg;
`ifdef FND_LZB_EN
        logic       upper_zero;
        upper_zero = 1'b1;
`endif
        nib = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (d == DIG_W'(i)) nib = bcd[4*i +: 4];
`ifdef FND_LZB_EN
            if (DIG_W'(i) >= d && bcd[4*i +: 4] != 4'd0) upper_zero = 1'b0;
`endif
        end
        case (nib)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = 8'hFF;
        endcase
        if (blank) seg = 8'hFF;
        else if (ovf) seg = 8'hBF;
`ifdef FND_LZB_EN
        else if (upper_zero && d != '0) seg = 8'hFF;
`endif
        if (auto_on && d == DIG_W'(DIGITS - 1)) seg[7] = 1'b0;
        return seg;
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_COMMIT} conv_state_t;

    conv_state_t       state;
    logic [CH_W-1:0]   ch_idx_q, sw_pick;
    logic              sw_any, auto_q, blank;
    logic [ROT_W-1:0]  rot_cnt;
    logic [DATA_W-1:0] sel_val, bin_q, bin_nxt;
    logic [BCD_W-1:0]  bcd_q, bcd_adj, bcd_nxt, disp_bcd;
    logic              ovf_q, disp_ovf, busy_q;
    logic [STEP_W-1:0] step_q;
    logic [SCAN_W-1:0] presc;
    logic [DIG_W-1:0]  digit_cnt, shown_q;
    logic              scan_on;
    logic [7:0]        font_next, font_cur;

    // Descending scan so the lowest set bit is the last (winning) assignment.
    always_comb begin
        sw_pick = '0;
        sw_any  = 1'b0;
        for (int unsigned k = NUM_CH; k > 0; k--) begin
            if (bus.sw[k-1]) begin
                sw_pick = CH_W'(k - 1);
                sw_any  = 1'b1;
            end
        end
    end

    always_comb begin
        sel_val = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (ch_idx_q == CH_W'(k)) sel_val = bus.ch_data[k*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ch_idx_q <= '0;
            rot_cnt  <= '0;
            auto_q   <= 1'b0;
        end else begin
            auto_q <= bus.mode_auto;
            if (bus.mode_auto) begin
                if (!auto_q) begin
                    rot_cnt <= '0;
                end else if (rot_cnt == ROT_W'(ROTATE_DIV - 1)) begin
                    rot_cnt  <= '0;
                    ch_idx_q <= (ch_idx_q == CH_W'(NUM_CH - 1)) ? '0 : ch_idx_q + CH_W'(1);
                end else begin
                    rot_cnt <= rot_cnt + ROT_W'(1);
                end
            end else begin
                rot_cnt <= '0;
                if (sw_any) ch_idx_q <= sw_pick;
            end
        end
    end

    // One double-dabble step: adjust every nibble, then shift bcd:bin left by one.
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (bcd_q[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
        end
        {bcd_nxt, bin_nxt} = {bcd_adj, bin_q} << 1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            bin_q    <= '0;
            bcd_q    <= '0;
            ovf_q    <= 1'b0;
            step_q   <= '0;
            busy_q   <= 1'b0;
            disp_bcd <= '0;
            disp_ovf <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    bin_q  <= sel_val;
                    busy_q <= 1'b1;
                    state  <= S_LOAD;
                end
                S_LOAD: begin
                    bcd_q  <= '0;
                    ovf_q  <= (64'(bin_q) >= OVF_LIMIT);
                    step_q <= '0;
                    state  <= S_SHIFT;
                end
                S_SHIFT: begin
                    bcd_q  <= bcd_nxt;
                    bin_q  <= bin_nxt;
                    step_q <= step_q + STEP_W'(1);
                    if (step_q == STEP_W'(DATA_W - 1)) state <= S_COMMIT;
                end
                S_COMMIT: begin
                    disp_bcd <= bcd_q;
                    disp_ovf <= ovf_q;
                    busy_q   <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        blank     = !bus.mode_auto && !sw_any;
        font_next = digit_font(disp_bcd, disp_ovf, blank, bus.mode_auto, digit_cnt);
        font_cur  = digit_font(disp_bcd, disp_ovf, blank, bus.mode_auto, shown_q);
    end

    // digit_cnt is the digit shown at the next scan step; shown_q is the one currently lit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc       <= '0;
            digit_cnt   <= '0;
            shown_q     <= '0;
            scan_on     <= 1'b0;
            bus.fndFont <= 8'hFF;
            bus.fndCom  <= '1;
        end else if (presc == SCAN_W'(SCAN_DIV - 1)) begin
            presc       <= '0;
            scan_on     <= 1'b1;
            shown_q     <= digit_cnt;
            digit_cnt   <= (digit_cnt == DIG_W'(DIGITS - 1)) ? '0 : digit_cnt + DIG_W'(1);
            bus.fndCom  <= ~(DIGITS'(1) << digit_cnt);
            bus.fndFont <= font_next;
        end else begin
            presc <= presc + SCAN_W'(1);
            if (scan_on) bus.fndFont <= font_cur;
        end
    end

    assign bus.ch_idx    = ch_idx_q;
    assign bus.conv_busy = busy_q;
endmodule

// File: tb/tb_fnd_multi_ctrl.sv
// Scoreboard bench for fnd_multi_ctrl: randomized channel traffic against an arithmetic display model.
module tb_fnd_multi_ctrl;
    localparam int NUM_CH     = 5;
    localparam int DATA_W     = 8;
    localparam int DIGITS     = 4;
    localparam int SCAN_DIV   = 4;
    localparam int ROTATE_DIV = 64;

    logic clk;
    logic reset;
    int   checks;
    int   passes;

    fnd_multi_ctrl_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DIGITS(DIGITS)) bus ();
    fnd_multi_ctrl_if #(.NUM_CH(2), .DATA_W(10), .DIGITS(2)) bus2 ();

    fnd_multi_ctrl #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DIGITS(DIGITS),
                     .SCAN_DIV(SCAN_DIV), .ROTATE_DIV(ROTATE_DIV))
        dut (.clk(clk), .reset(reset), .bus(bus));

    fnd_multi_ctrl #(.NUM_CH(2), .DATA_W(10), .DIGITS(2), .SCAN_DIV(4), .ROTATE_DIV(64))
        dut2 (.clk(clk), .reset(reset), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:0] seg_code(input int unsigned n);
        case (n)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // Expected segments for digit d of a decimal display of val.
    function automatic logic [7:0] exp_font(input int unsigned val, input int unsigned d,
                                            input int unsigned digits, input bit blank,
                                            input bit auto_on);
        logic [7:0]  s;
        int unsigned p;
        int unsigned lim;
        p = 1;
        for (int unsigned i = 0; i < d; i++) p = p * 10;
        lim = 1;
        for (int unsigned i = 0; i < digits; i++) lim = lim * 10;
        if (blank) s = 8'hFF;
        else if (val >= lim) s = 8'hBF;
        else begin
            s = seg_code((val / p) % 10);
`ifdef FND_LZB_EN
            if (d > 0 && val < p) s = 8'hFF;
`endif
        end
        if (auto_on && d == digits - 1) s[7] = 1'b0;
        return s;
    endfunction

    function automatic int unsigned lowest_bit(input logic [NUM_CH-1:0] s);
        for (int unsigned i = 0; i < NUM_CH; i++) if (s[i]) return i;
        return 0;
    endfunction

    // Reference channel model plus a snapshot of the inputs as seen at each edge.
    int unsigned           m_ch, pre_ch, auto_cyc;
    bit                    m_auto_prev;
    logic [NUM_CH*DATA_W-1:0] pre_data;
    logic [NUM_CH-1:0]     pre_sw;
    logic                  pre_mode;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_ch        <= 0;
            m_auto_prev <= 1'b0;
            auto_cyc    <= 0;
        end else begin
            pre_ch      <= m_ch;
            pre_data    <= bus.ch_data;
            pre_sw      <= bus.sw;
            pre_mode    <= bus.mode_auto;
            m_auto_prev <= bus.mode_auto;
            if (bus.mode_auto) begin
                if (!m_auto_prev) auto_cyc <= 0;
                else begin
                    auto_cyc <= auto_cyc + 1;
                    if ((auto_cyc + 1) % ROTATE_DIV == 0) m_ch <= (m_ch + 1) % NUM_CH;
                end
            end else if (bus.sw != '0) begin
                m_ch <= lowest_bit(bus.sw);
            end
        end
    end

    // Monitor: expected value queued when a conversion starts, consumed when it commits.
    int unsigned expq[$];

    initial begin
        int          busy_len, gap, prev_d, d;
        bit          busy_prev, have_prev;
        logic [3:0]  com_prev;
        int unsigned shown;
        busy_len = 0; gap = 0; prev_d = 0; d = 0;
        busy_prev = 1'b0; have_prev = 1'b0; com_prev = 4'hF; shown = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                expq.delete();
                shown = 0; busy_prev = 1'b0; busy_len = 0;
                com_prev = 4'hF; gap = 0; have_prev = 1'b0;
            end else begin
                check("ch_idx", bus.ch_idx, m_ch);
                gap++;
                if (bus.fndCom != 4'hF) begin
                    for (int i = DIGITS - 1; i >= 0; i--) if (!bus.fndCom[i]) d = i;
                    check("com_onehot", $countones(bus.fndCom), DIGITS - 1);
                    check("font", bus.fndFont,
                          exp_font(shown, d, DIGITS, (pre_sw == '0) && !pre_mode, pre_mode));
                end
                if (bus.fndCom != com_prev) begin
                    if (have_prev) begin
                        check("scan_period", gap, SCAN_DIV);
                        check("scan_order", d, (prev_d + 1) % DIGITS);
                    end
                    have_prev = 1'b1; prev_d = d; gap = 0; com_prev = bus.fndCom;
                end
                if (bus.conv_busy) busy_len++;
                if (bus.conv_busy && !busy_prev)
                    expq.push_back(int'(pre_data[pre_ch*DATA_W +: DATA_W]));
                if (!bus.conv_busy && busy_prev) begin
                    check("busy_len", busy_len, DATA_W + 2);
                    busy_len = 0;
                    check("commit_pending", expq.size(), 1);
                    if (expq.size() > 0) shown = expq.pop_front();
                end
                busy_prev = bus.conv_busy;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check_reset_vals();
        check("rst_font", bus.fndFont, 8'hFF);
        check("rst_com", bus.fndCom, 4'hF);
        check("rst_ch_idx", bus.ch_idx, 0);
        check("rst_busy", bus.conv_busy, 0);
    endtask

    task automatic first_scan();
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (bus.fndCom == 4'hF && n < 50);
        check("first_scan_delay", n, SCAN_DIV);
        check("first_scan_com", bus.fndCom, 4'b1110);
        check("first_scan_font", bus.fndFont, 8'hC0);
    endtask

    task automatic wait_busy_edge(input bit level);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (bus.conv_busy != level && n < 40);
        check("busy_wait", bus.conv_busy, level);
    endtask

    task automatic digit1(input int d, output logic [7:0] f);
        int n;
        logic [3:0] tgt;
        tgt = ~(4'(1) << d);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.fndCom != tgt && n < 40);
        check("digit_seen", bus.fndCom, tgt);
        f = bus.fndFont;
    endtask

    task automatic digit2(input int d, output logic [7:0] f);
        int n;
        logic [1:0] tgt;
        tgt = ~(2'(1) << d);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus2.fndCom != tgt && n < 40);
        check("digit2_seen", bus2.fndCom, tgt);
        f = bus2.fndFont;
    endtask

    initial begin
        logic [7:0] f;
        logic [7:0] top_exp;
        checks = 0;
        passes = 0;
        reset = 1'b0;
        bus.sw = 5'b00001;
        bus.mode_auto = 1'b0;
        for (int k = 0; k < NUM_CH; k++) bus.ch_data[k*DATA_W +: DATA_W] = 8'($urandom);
        bus2.sw = 2'b01;
        bus2.mode_auto = 1'b0;
        bus2.ch_data = {10'd0, 10'd99};

        #12;
        check_reset_vals();
        @(posedge clk); #2 reset = 1'b1;
        first_scan();

        // Reset asserted in the middle of a conversion
        bus.sw = 5'b01000;
        wait_busy_edge(1'b0);
        wait_busy_edge(1'b1);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1 check_reset_vals();
        @(posedge clk); @(posedge clk);
        #2 reset = 1'b1;
        first_scan();

        // Priority select then a specific 3-digit value
        bus.ch_data[2*DATA_W +: DATA_W] = 8'd255;
        bus.sw = 5'b00110;
        step(30);
        check("prio_ch_idx", bus.ch_idx, 1);
        bus.sw = 5'b00100;
        step(40);
        check("sel_ch_idx", bus.ch_idx, 2);
`ifdef FND_LZB_EN
        top_exp = 8'hFF;
`else
        top_exp = 8'hC0;
`endif
        digit1(0, f); check("val255_d0", f, 8'h92);
        digit1(1, f); check("val255_d1", f, 8'h92);
        digit1(2, f); check("val255_d2", f, 8'hA4);
        digit1(3, f); check("val255_d3", f, top_exp);

        // No switch: blank display, channel held, scan continues
        bus.sw = '0;
        step(20);
        check("blank_ch_hold", bus.ch_idx, 2);
        for (int i = 0; i < DIGITS; i++) begin
            digit1(i, f);
            check("blank_font", f, 8'hFF);
        end

        // Data change in flight on the selected channel
        bus.sw = 5'b00001;
        bus.ch_data[0 +: DATA_W] = 8'd42;
        step(30);
        wait_busy_edge(1'b0);
        wait_busy_edge(1'b1);
        step(3);
        bus.ch_data[0 +: DATA_W] = 8'd199;
        step(40);

        // Randomized manual traffic
        repeat (40) begin
            if ($urandom_range(0, 7) == 0) bus.sw = '0;
            else bus.sw = 5'($urandom);
            if ($urandom_range(0, 1) == 1)
                bus.ch_data[$urandom_range(0, NUM_CH - 1)*DATA_W +: DATA_W] = 8'($urandom);
            step($urandom_range(1, 25));
        end

        // Auto-rotate across a full cycle of channels
        bus.sw = 5'($urandom);
        bus.mode_auto = 1'b1;
        repeat (6) begin
            step(ROTATE_DIV);
            bus.ch_data[$urandom_range(0, NUM_CH - 1)*DATA_W +: DATA_W] = 8'($urandom);
        end
        bus.mode_auto = 1'b0;
        bus.sw = 5'b10000;
        step(30);

        // Two-digit instance: largest displayable value, then overflow
        digit2(0, f); check("w10_99_d0", f, 8'h90);
        digit2(1, f); check("w10_99_d1", f, 8'h90);
        bus2.ch_data[9:0] = 10'd100;
        step(40);
        digit2(0, f); check("w10_ovf_d0", f, 8'hBF);
        digit2(1, f); check("w10_ovf_d1", f, 8'hBF);

        step(5);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
